// File: rtl/nvdla_pdp_med1d_seq.sv
// Purpose : serial window sequencer for the PDP 1D median/min pairwise core;
//           folds K elements into one result, one element per cycle.
// Latency : result valid the cycle after the K-th element is accepted; a
//           window occupies at least K+1 cycles (no overlap with OUT).
// Backpr. : pdp_in_rdy is low while a result is pending; pdp_out_vld/pd hold
//           until pdp_out_rdy; input bubbles simply stretch the window.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst    clock, synchronous active-high reset
//   reg2dp_*                           precision selects and kernel width (K-1)
//   pdp_in_vld/rdy/pd                  element stream in
//   core_enable, core_*_en,
//   core_data0/1, core_result          handshake-free link to the combinational
//                                      pairwise core (acc op element)
//   pdp_out_vld/rdy/pd                 one result per window
//   cfg_err                            sticky, precision not one-hot at window start
//   win_cnt                            number of windows emitted, wraps
module nvdla_pdp_med1d_seq #(
  parameter int DW      = 22,
  parameter int KW_BITS = 3,
  parameter int CNT_W   = 16
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic               reg2dp_int8_en,
  input  logic               reg2dp_int16_en,
  input  logic               reg2dp_fp16_en,
  input  logic [KW_BITS-1:0] reg2dp_kernel_width,
  input  logic               pdp_in_vld,
  output logic               pdp_in_rdy,
  input  logic [DW-1:0]      pdp_in_pd,
  output logic               core_enable,
  output logic               core_int8_en,
  output logic               core_int16_en,
  output logic               core_fp16_en,
  output logic [DW-1:0]      core_data0,
  output logic [DW-1:0]      core_data1,
  input  logic [DW-1:0]      core_result,
  output logic               pdp_out_vld,
  input  logic               pdp_out_rdy,
  output logic [DW-1:0]      pdp_out_pd,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   win_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  localparam logic [KW_BITS:0] K_ONE   = {{KW_BITS{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [DW-1:0]      r_acc;
  logic [DW-1:0]      r_out_pd;
  logic               r_out_vld;
  logic [KW_BITS:0]   r_k;
  logic [KW_BITS:0]   r_elem_cnt;
  logic               r_int8;
  logic               r_int16;
  logic               r_fp16;
  logic               r_cfg_err;
  logic [CNT_W-1:0]   r_win_cnt;

  logic               w_in_acc;
  logic               w_accum_fire;
  logic               w_onehot;
  logic [KW_BITS:0]   w_k_new;
  logic [KW_BITS:0]   w_cnt_nxt;

  // Ready is masked during reset so nothing is accepted in the reset cycle.
  assign pdp_in_rdy   = !nvdla_core_rst && ((r_state == S_IDLE) || (r_state == S_ACCUM));
  assign w_in_acc     = pdp_in_vld && pdp_in_rdy;
  assign w_accum_fire = w_in_acc && (r_state == S_ACCUM);

  // Core operands are forced to zero when no fold happens so the core's
  // inputs stay quiet between elements.
  assign core_enable   = w_accum_fire;
  assign core_data0    = w_accum_fire ? r_acc     : '0;
  assign core_data1    = w_accum_fire ? pdp_in_pd : '0;
  assign core_int8_en  = r_int8;
  assign core_int16_en = r_int16;
  assign core_fp16_en  = r_fp16;

  assign w_k_new   = {1'b0, reg2dp_kernel_width} + K_ONE;
  assign w_cnt_nxt = r_elem_cnt + K_ONE;
  assign w_onehot  = ( reg2dp_int8_en && !reg2dp_int16_en && !reg2dp_fp16_en) ||
                     (!reg2dp_int8_en &&  reg2dp_int16_en && !reg2dp_fp16_en) ||
                     (!reg2dp_int8_en && !reg2dp_int16_en &&  reg2dp_fp16_en);

  assign pdp_out_vld = r_out_vld;
  assign pdp_out_pd  = r_out_pd;
  assign cfg_err     = r_cfg_err;
  assign win_cnt     = r_win_cnt;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_out_pd   <= '0;
      r_out_vld  <= 1'b0;
      r_k        <= '0;
      r_elem_cnt <= '0;
      r_int8     <= 1'b0;
      r_int16    <= 1'b0;
      r_fp16     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_win_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_acc) begin
            // Config is captured only here; later register changes are
            // invisible until the next window opens.
            r_k        <= w_k_new;
            r_int8     <= reg2dp_int8_en;
            r_int16    <= reg2dp_int16_en;
            r_fp16     <= reg2dp_fp16_en;
            r_acc      <= pdp_in_pd;
            r_elem_cnt <= K_ONE;
            if (!w_onehot) begin
              r_cfg_err <= 1'b1;
            end
            if (w_k_new == K_ONE) begin
              r_out_vld <= 1'b1;
              r_out_pd  <= pdp_in_pd;
              r_state   <= S_OUT;
            end else begin
              r_state   <= S_ACCUM;
            end
          end
        end

        S_ACCUM: begin
          if (w_accum_fire) begin
            r_acc      <= core_result;
            r_elem_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_k) begin
              r_out_vld <= 1'b1;
              r_out_pd  <= core_result;
              r_state   <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (pdp_out_rdy) begin
            // Window closed: drop latched precision so the core sees zeros
            // outside a window.
            r_out_vld  <= 1'b0;
            r_win_cnt  <= r_win_cnt + CNT_ONE;
            r_k        <= '0;
            r_elem_cnt <= '0;
            r_int8     <= 1'b0;
            r_int16    <= 1'b0;
            r_fp16     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: begin
          r_out_vld <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nvdla_pdp_med1d_seq.sv
// Purpose : self-checking bench for nvdla_pdp_med1d_seq with a behavioural
//           pairwise core and a result scoreboard.
// Latency : n/a (bench).
// Backpr. : exercises held and randomly toggling pdp_out_rdy.
module tb_nvdla_pdp_med1d_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg2dp_int8_en, reg2dp_int16_en, reg2dp_fp16_en;
  logic [2:0]  reg2dp_kernel_width;
  logic        pdp_in_vld;
  logic        pdp_in_rdy;
  logic [21:0] pdp_in_pd;
  logic        core_enable, core_int8_en, core_int16_en, core_fp16_en;
  logic [21:0] core_data0, core_data1, core_result;
  logic        pdp_out_vld;
  logic        pdp_out_rdy;
  logic [21:0] pdp_out_pd;
  logic        cfg_err;
  logic [15:0] win_cnt;

  int          n_chk = 0;
  int          n_pass = 0;
  int          win_exp = 0;
  int          core_en_cnt = 0;
  bit          rnd_rdy = 0;
  bit          prev_hold = 0;
  logic [21:0] prev_pd;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  nvdla_pdp_med1d_seq dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rst      (rst),
    .reg2dp_int8_en      (reg2dp_int8_en),
    .reg2dp_int16_en     (reg2dp_int16_en),
    .reg2dp_fp16_en      (reg2dp_fp16_en),
    .reg2dp_kernel_width (reg2dp_kernel_width),
    .pdp_in_vld          (pdp_in_vld),
    .pdp_in_rdy          (pdp_in_rdy),
    .pdp_in_pd           (pdp_in_pd),
    .core_enable         (core_enable),
    .core_int8_en        (core_int8_en),
    .core_int16_en       (core_int16_en),
    .core_fp16_en        (core_fp16_en),
    .core_data0          (core_data0),
    .core_data1          (core_data1),
    .core_result         (core_result),
    .pdp_out_vld         (pdp_out_vld),
    .pdp_out_rdy         (pdp_out_rdy),
    .pdp_out_pd          (pdp_out_pd),
    .cfg_err             (cfg_err),
    .win_cnt             (win_cnt)
  );

  // Behavioural pairwise core: zero operand loses, otherwise the smaller
  // value wins (signed int, or fp16 ordering); no precision selected -> 0.
  function automatic logic [21:0] core_fn(input logic [21:0] a, input logic [21:0] b,
                                          input logic i8, input logic i16, input logic f16);
    logic [15:0] ka, kb;
    ka = a[15] ? ~a[15:0] : (a[15:0] | 16'h8000);
    kb = b[15] ? ~b[15:0] : (b[15:0] | 16'h8000);
    if (!(i8 || i16 || f16)) return 22'd0;
    if (a == 22'd0) return b;
    if (b == 22'd0) return a;
    if (f16) return (kb < ka) ? b : a;
    return ($signed(b) < $signed(a)) ? b : a;
  endfunction

  assign core_result = core_fn(core_data0, core_data1, core_int8_en, core_int16_en, core_fp16_en);

  function automatic logic [21:0] ref_reduce(input logic [21:0] e[8], input int k, input logic [2:0] prec);
    logic [21:0] acc;
    acc = e[0];
    for (int i = 1; i < k; i++) acc = core_fn(acc, e[i], prec[0], prec[1], prec[2]);
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  // Output monitor: scoreboard pop on handshake, hold-stability check.
  always @(negedge clk) begin
    if (core_enable) core_en_cnt++;
    if (rst) begin
      win_exp   = 0;
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("out_hold_vld", {31'd0, pdp_out_vld}, 32'd1);
        chk("out_hold_pd", {10'd0, pdp_out_pd}, {10'd0, prev_pd});
      end
      prev_hold = pdp_out_vld && !pdp_out_rdy;
      prev_pd   = pdp_out_pd;
      if (pdp_out_vld && pdp_out_rdy) begin
        win_exp++;
        if (exp_q.size() == 0) chk("unexpected_out", {10'd0, pdp_out_pd}, 32'hFFFFFFFF);
        else chk("out_pd", {10'd0, pdp_out_pd}, {10'd0, exp_q.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      pdp_out_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [21:0] d);
    int t;
    t = 0;
    pdp_in_vld = 1'b1;
    pdp_in_pd  = d;
    @(negedge clk);
    while (!pdp_in_rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!pdp_in_rdy) chk("in_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    pdp_in_vld = 1'b0;
    pdp_in_pd  = '0;
  endtask

  task automatic set_cfg(input int k, input logic [2:0] prec);
    reg2dp_kernel_width = 3'(k - 1);
    reg2dp_int8_en      = prec[0];
    reg2dp_int16_en     = prec[1];
    reg2dp_fp16_en      = prec[2];
  endtask

  // prec = {fp16, int16, int8}
  task automatic run_window(input int k, input logic [2:0] prec, input logic [21:0] e[8],
                            input int maxgap, input bit scramble);
    set_cfg(k, prec);
    for (int i = 0; i < k; i++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      send(e[i]);
      if (i == 0 && scramble) begin
        reg2dp_kernel_width = 3'($urandom);
        reg2dp_int8_en      = 1'($urandom);
        reg2dp_int16_en     = 1'($urandom);
        reg2dp_fp16_en      = 1'($urandom);
      end
    end
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || pdp_out_vld) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || pdp_out_vld) begin
      chk("out_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_rdy", {31'd0, pdp_in_rdy}, 32'd0);
    chk("rst_out_vld", {31'd0, pdp_out_vld}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [21:0] e[8];
    logic [2:0]  prec;
    int          k;
    int          base;

    rst = 1'b1;
    pdp_in_vld = 1'b0;
    pdp_in_pd = '0;
    pdp_out_rdy = 1'b1;
    set_cfg(1, 3'b000);

    // Reset state
    @(negedge clk);
    chk("rst_in_rdy", {31'd0, pdp_in_rdy}, 32'd0);
    chk("rst_out_vld", {31'd0, pdp_out_vld}, 32'd0);
    chk("rst_out_pd", {10'd0, pdp_out_pd}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_win_cnt", {16'd0, win_cnt}, 32'd0);
    chk("rst_core_ctl", {24'd0, core_enable, core_int8_en, core_int16_en, core_fp16_en,
                         2'b00, |core_data0, |core_data1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_rdy", {31'd0, pdp_in_rdy}, 32'd1);
    @(posedge clk); #1;

    // int16, K=3: 0, 4, -2 -> -2, result one cycle after 3rd element
    set_cfg(3, 3'b010);
    exp_q.push_back(22'h3FFFFE);
    send(22'h000000);
    send(22'h000004);
    send(22'h3FFFFE);
    @(negedge clk);
    chk("t1_latency_vld", {31'd0, pdp_out_vld}, 32'd1);
    wait_out();
    chk("t1_win_cnt", {16'd0, win_cnt}, 32'd1);
    chk("t1_prec_cleared", {29'd0, core_int8_en, core_int16_en, core_fp16_en}, 32'd0);

    // fp16, K=2: 1.0, -1.0 -> -1.0, one core_enable cycle
    base = core_en_cnt;
    set_cfg(2, 3'b100);
    exp_q.push_back(22'h00BC00);
    send(22'h003C00);
    send(22'h00BC00);
    wait_out();
    chk("t2_core_en_cycles", core_en_cnt - base, 32'd1);

    // K=1, int8: passthrough next cycle, core never enabled
    base = core_en_cnt;
    set_cfg(1, 3'b001);
    exp_q.push_back(22'h000055);
    send(22'h000055);
    @(negedge clk);
    chk("t3_latency_vld", {31'd0, pdp_out_vld}, 32'd1);
    wait_out();
    chk("t3_core_en_cycles", core_en_cnt - base, 32'd0);

    // K=4, int16, output held for 5 cycles
    pdp_out_rdy = 1'b0;
    set_cfg(4, 3'b010);
    exp_q.push_back(22'h3FFFF0);
    send(22'h000005);
    send(22'h3FFFF0);
    send(22'h000007);
    send(22'h000000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_vld", {31'd0, pdp_out_vld}, 32'd1);
      chk("t4_hold_pd", {10'd0, pdp_out_pd}, 32'h3FFFF0);
      chk("t4_hold_in_rdy", {31'd0, pdp_in_rdy}, 32'd0);
    end
    @(posedge clk); #1;
    pdp_out_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_idle_in_rdy", {31'd0, pdp_in_rdy}, 32'd1);
    chk("t4_idle_out_vld", {31'd0, pdp_out_vld}, 32'd0);
    chk("t4_win_cnt", {16'd0, win_cnt}, 32'd4);
    @(posedge clk); #1;

    // Reset after 2 of 4 elements: partial window discarded
    set_cfg(4, 3'b010);
    send(22'h000011);
    send(22'h000022);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_out", {31'd0, pdp_out_vld}, 32'd0);
    end
    chk("t5_win_cnt_rst", {16'd0, win_cnt}, 32'd0);
    @(posedge clk); #1;
    e = '{22'h000009, 22'h000003, 22'h3FFFFF, 22'h000002, 22'd0, 22'd0, 22'd0, 22'd0};
    exp_q.push_back(22'h3FFFFF);
    run_window(4, 3'b010, e, 0, 0);
    wait_out();
    chk("t5_win_cnt", {16'd0, win_cnt}, 32'd1);
    chk("cfg_err_clean", {31'd0, cfg_err}, 32'd0);

    // int16+fp16 both set: cfg_err sticks through later valid windows
    e = '{22'h000003, 22'h000009, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0};
    exp_q.push_back(22'h000003);
    run_window(2, 3'b110, e, 0, 0);
    wait_out();
    chk("t6_cfg_err_set", {31'd0, cfg_err}, 32'd1);
    e = '{22'h000010, 22'h000020, 22'h000008, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0};
    exp_q.push_back(22'h000008);
    run_window(3, 3'b001, e, 0, 0);
    wait_out();
    chk("t6_cfg_err_sticky", {31'd0, cfg_err}, 32'd1);

    // No precision: K>1 gives 0, K==1 gives the element
    e = '{22'h000005, 22'h000006, 22'h000007, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0};
    exp_q.push_back(22'h000000);
    run_window(3, 3'b000, e, 0, 0);
    e = '{22'h000123, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0};
    exp_q.push_back(22'h000123);
    run_window(1, 3'b000, e, 0, 0);
    wait_out();

    // Random windows: bubbles, mid-window config churn, random out_rdy
    rnd_rdy = 1;
    for (int w = 0; w < 14; w++) begin
      k = $urandom_range(1, 8);
      prec = 3'b001 << $urandom_range(0, 2);
      for (int i = 0; i < 8; i++)
        e[i] = ($urandom_range(0, 3) == 0) ? 22'd0 : 22'($urandom);
      exp_q.push_back(ref_reduce(e, k, prec));
      run_window(k, prec, e, 2, 1);
    end
    rnd_rdy = 0;
    @(posedge clk); #2;
    pdp_out_rdy = 1'b1;
    wait_out();
    chk("win_cnt_total", {16'd0, win_cnt}, 32'(win_exp));

    // cfg_err clears only on reset
    do_reset();
    @(negedge clk);
    chk("cfg_err_cleared", {31'd0, cfg_err}, 32'd0);
    chk("win_cnt_cleared", {16'd0, win_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
